// File: rtl/riscv_pkg.sv
// Shared constants for the integer pipeline: default datapath width and the
// bit layout of the decode control bundle.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 64;

  // Control bundle layout: {alu_op[1:0], alu_src, branch, mem_to_reg,
  // mem_write, mem_read, reg_write}
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_ALU_OP     = 6;  // lsb of the two-bit alu_op field
  localparam int CTRL_W          = 8;

  localparam int REG_IDX_W = 5;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the
// destination of a load still sitting in the execute stage.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 load_use
);

  logic [REG_IDX_W-1:0] src_idx [2];
  logic [1:0]           src_hit;

  assign src_idx[0] = id_rs1;
  assign src_idx[1] = id_rs2;

  // One comparator per source operand; a shared match on both sources still
  // yields a single hazard indication.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
      assign src_hit[gi] = (src_idx[gi] == ex_rd);
    end
  endgenerate

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = id_valid & ex_valid & ex_mem_read &
                    (ex_rd != '0) & (|src_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating count of inserted bubbles.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int CNTW = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [XLEN-1:0]         id_pc,
  input  logic [REG_IDX_W-1:0]    id_rs1,
  input  logic [REG_IDX_W-1:0]    id_rs2,
  input  logic [REG_IDX_W-1:0]    id_rd,
  input  logic signed [XLEN-1:0]  id_read_data1,
  input  logic signed [XLEN-1:0]  id_read_data2,
  input  logic signed [XLEN-1:0]  id_imm,
  input  logic [CTRL_W-1:0]       id_ctrl,
  input  logic                    flush,
  input  logic                    hold,
  output logic                    stall,
  output logic                    ex_valid,
  output logic [XLEN-1:0]         ex_pc,
  output logic [REG_IDX_W-1:0]    ex_rs1,
  output logic [REG_IDX_W-1:0]    ex_rs2,
  output logic [REG_IDX_W-1:0]    ex_rd,
  output logic signed [XLEN-1:0]  ex_read_data1,
  output logic signed [XLEN-1:0]  ex_read_data2,
  output logic signed [XLEN-1:0]  ex_imm,
  output logic [CTRL_W-1:0]       ex_ctrl,
  output logic [CNTW-1:0]         bubble_count
);

  logic                   valid_reg;
  logic [XLEN-1:0]        pc_reg;
  logic [REG_IDX_W-1:0]   rs1_reg;
  logic [REG_IDX_W-1:0]   rs2_reg;
  logic [REG_IDX_W-1:0]   rd_reg;
  logic signed [XLEN-1:0] data1_reg;
  logic signed [XLEN-1:0] data2_reg;
  logic signed [XLEN-1:0] imm_reg;
  logic [CTRL_W-1:0]      ctrl_reg;
  logic [CNTW-1:0]        bubble_count_reg;
  logic [CNTW-1:0]        bubble_count_next;
  logic                   load_use;

  hazard_detect u_hazard_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (valid_reg),
    .ex_mem_read (ctrl_reg[CTRL_MEM_READ]),
    .ex_rd       (rd_reg),
    .load_use    (load_use)
  );

  // Freeze upstream on a hazard or downstream wait, unless the decode
  // instruction is being squashed anyway; hold is ignored during reset.
  assign stall = (load_use | (hold & ~reset)) & ~flush;

  // Saturating increment so the counter sticks at all-ones.
  assign bubble_count_next = (&bubble_count_reg) ? bubble_count_reg
                                                 : bubble_count_reg + 1'b1;

  // Pipeline register update: flush > hold > load-use bubble > capture.
  // Bubbles and flushes only clear valid/ctrl; the data fields are left as
  // they were since nothing downstream looks at them while valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg        <= 1'b0;
      pc_reg           <= '0;
      rs1_reg          <= '0;
      rs2_reg          <= '0;
      rd_reg           <= '0;
      data1_reg        <= '0;
      data2_reg        <= '0;
      imm_reg          <= '0;
      ctrl_reg         <= '0;
      bubble_count_reg <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end else if (hold) begin
      valid_reg <= valid_reg;
    end else if (load_use) begin
      valid_reg        <= 1'b0;
      ctrl_reg         <= '0;
      bubble_count_reg <= bubble_count_next;
    end else begin
      valid_reg <= id_valid;
      pc_reg    <= id_pc;
      rs1_reg   <= id_rs1;
      rs2_reg   <= id_rs2;
      rd_reg    <= id_rd;
      data1_reg <= id_read_data1;
      data2_reg <= id_read_data2;
      imm_reg   <= id_imm;
      ctrl_reg  <= id_valid ? id_ctrl : '0;
    end
  end

  assign ex_valid      = valid_reg;
  assign ex_pc         = pc_reg;
  assign ex_rs1        = rs1_reg;
  assign ex_rs2        = rs2_reg;
  assign ex_rd         = rd_reg;
  assign ex_read_data1 = data1_reg;
  assign ex_read_data2 = data2_reg;
  assign ex_imm        = imm_reg;
  assign ex_ctrl       = ctrl_reg;
  assign bubble_count  = bubble_count_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes hand-computed expected
// results per cycle, a separate monitor pops and compares them.
module tb_id_ex_stage;

  localparam int XLEN = 64;
  localparam int CNTW = 2;
  localparam int LD   = 8'h0B;  // reg_write | mem_read | mem_to_reg
  localparam int ALU  = 8'h01;  // reg_write only

  typedef struct {
    bit     v;
    int     rs1, rs2, rd;
    longint d1;
    int     ctrl;
    bit     fl, ho;
  } in_t;

  typedef struct {
    bit     st, v;
    int     rs1, rs2, rd;
    longint d1;
    int     ctrl, bc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic id_valid = 1'b0;
  logic [XLEN-1:0] id_pc = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic signed [XLEN-1:0] id_read_data1 = '0, id_read_data2 = '0, id_imm = '0;
  logic [7:0] id_ctrl = '0;
  logic flush = 1'b0, hold = 1'b0;
  logic stall, ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic signed [XLEN-1:0] ex_read_data1, ex_read_data2, ex_imm;
  logic [7:0] ex_ctrl;
  logic [CNTW-1:0] bubble_count;

  int errors = 0;
  int checks = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush), .hold(hold),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_read_data1(ex_read_data1),
    .ex_read_data2(ex_read_data2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .bubble_count(bubble_count)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Drive one decode-stage instruction at the falling edge and queue the
  // hand-computed result expected after the following rising edge.
  task automatic step(input in_t i, input exp_t e);
    @(negedge clk);
    id_valid      = i.v;
    id_rs1        = 5'(i.rs1);
    id_rs2        = 5'(i.rs2);
    id_rd         = 5'(i.rd);
    id_read_data1 = i.d1;
    id_read_data2 = i.d1 * 2;
    id_imm        = -i.d1;
    id_pc         = 64'h1000 + i.d1;
    id_ctrl       = 8'(i.ctrl);
    flush         = i.fl;
    hold          = i.ho;
    q.push_back(e);
  endtask

  // Monitor: stall is sampled mid-cycle with inputs settled, the registered
  // outputs just after the rising edge.
  initial begin : monitor
    exp_t e;
    int   n;
    logic st;
    n = 0;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e  = q.pop_front();
        st = stall;
        @(posedge clk);
        #1;
        n++;
        $display("txn %0d: stall=%0b ex_valid=%0b ex_rd=%0d ex_ctrl=%02h bubbles=%0d",
                 n, st, ex_valid, ex_rd, ex_ctrl, bubble_count);
        chk("stall", longint'(st), longint'(e.st));
        chk("ex_valid", longint'(ex_valid), longint'(e.v));
        chk("ex_ctrl", longint'(ex_ctrl), longint'(e.ctrl));
        chk("bubble_count", longint'(bubble_count), longint'(e.bc));
        if (e.v) begin
          chk("ex_rs1", longint'(ex_rs1), longint'(e.rs1));
          chk("ex_rs2", longint'(ex_rs2), longint'(e.rs2));
          chk("ex_rd", longint'(ex_rd), longint'(e.rd));
          chk("ex_read_data1", ex_read_data1, e.d1);
          chk("ex_read_data2", ex_read_data2, e.d1 * 2);
          chk("ex_imm", ex_imm, -e.d1);
          chk("ex_pc", longint'(ex_pc), 64'h1000 + e.d1);
        end
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    chk("queue_drained", longint'(q.size()), 0);
    @(posedge clk);
    #2;
  endtask

  task automatic reset_checks(input string tag);
    $display("reset check %s: ex_valid=%0b bubbles=%0d stall=%0b", tag, ex_valid, bubble_count, stall);
    chk({tag, "_ex_valid"}, longint'(ex_valid), 0);
    chk({tag, "_ex_ctrl"}, longint'(ex_ctrl), 0);
    chk({tag, "_ex_rd"}, longint'(ex_rd), 0);
    chk({tag, "_ex_pc"}, longint'(ex_pc), 0);
    chk({tag, "_ex_data1"}, ex_read_data1, 0);
    chk({tag, "_bubble_count"}, longint'(bubble_count), 0);
    chk({tag, "_stall"}, longint'(stall), 0);
  endtask

  initial begin : driver
    // Asynchronous reset between edges, with hold high to show it is masked.
    hold = 1'b1;
    #1 reset = 1'b1;
    #1 reset_checks("por");
    @(negedge clk);
    reset = 1'b0;
    hold  = 1'b0;

    //        v rs1 rs2 rd  d1 ctrl fl ho      st v rs1 rs2 rd  d1 ctrl bc
    step('{1, 1, 2, 5, -3, ALU, 0, 0}, '{0, 1, 1, 2, 5, -3, ALU, 0});   // pass-through
    step('{1, 3, 4, 7, 10, LD, 0, 0},  '{0, 1, 3, 4, 7, 10, LD, 0});    // ld x7
    step('{1, 8, 7, 9, 20, ALU, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 1});      // uses x7 -> bubble
    step('{1, 8, 7, 9, 20, ALU, 0, 0}, '{0, 1, 8, 7, 9, 20, ALU, 1});   // captured after bubble
    step('{1, 1, 2, 0, 30, LD, 0, 0},  '{0, 1, 1, 2, 0, 30, LD, 1});    // ld x0
    step('{1, 0, 0, 3, 40, ALU, 0, 0}, '{0, 1, 0, 0, 3, 40, ALU, 1});   // x0 never hazards
    step('{1, 1, 1, 6, 50, LD, 0, 0},  '{0, 1, 1, 1, 6, 50, LD, 1});    // ld x6
    step('{1, 6, 6, 12, 60, ALU, 1, 1}, '{0, 0, 0, 0, 0, 0, 0, 1});     // flush beats all
    step('{1, 1, 1, 6, 50, LD, 0, 0},  '{0, 1, 1, 1, 6, 50, LD, 1});    // ld x6 again
    step('{1, 6, 6, 12, 60, ALU, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 2});     // rs1=rs2: one bubble
    step('{1, 6, 6, 12, 60, ALU, 0, 0}, '{0, 1, 6, 6, 12, 60, ALU, 2}); // not two

    // Five more load/use pairs: the 2-bit counter must stick at 3.
    for (int k = 0; k < 5; k++) begin
      step('{1, 1, 1, 6, 50, LD, 0, 0}, '{0, 1, 1, 1, 6, 50, LD, (2 + k > 3) ? 3 : 2 + k});
      step('{1, 6, 6, 12, 60, ALU, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 3});
    end
    step('{1, 6, 6, 12, 60, ALU, 0, 0}, '{0, 1, 6, 6, 12, 60, ALU, 3});

    // Hold for three cycles with different decode inputs: nothing moves.
    for (int k = 0; k < 3; k++)
      step('{1, 1, 2, 5, 99, ALU, 0, 1}, '{1, 1, 6, 6, 12, 60, ALU, 3});
    drain();

    // Reset in the middle of a hold clears everything without a clock.
    @(negedge clk);
    hold = 1'b1;
    #2 reset = 1'b1;
    #1 reset_checks("midhold");
    @(negedge clk);
    reset = 1'b0;
    hold  = 1'b0;
    step('{1, 2, 3, 4, -7, ALU, 0, 0}, '{0, 1, 2, 3, 4, -7, ALU, 0});
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
